// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter state encoding; values are fixed so waveforms stay readable.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    // Data grants allowed to bypass a waiting fetch before it is promoted.
    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants that bypassed a waiting fetch.
// MAX = 0 never saturates, which turns fetch promotion off entirely.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(MAX));
    assign sat_o  = (MAX != 0) && at_max;

    // Next count: clear wins, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// One transaction in flight; data wins unless a fetch has been bypassed
// STARVE_MAX times in a row. Command is latched at grant and held until ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_mem
);

    arb_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic d_req;
    logic promote;
    logic grant_d;
    logic grant_i;
    logic if_done;
    logic d_done;

    assign d_req   = d_rd | d_wr;
    assign grant_d = (state_q == IDLE) && d_req && !(if_req && promote);
    assign grant_i = (state_q == IDLE) && !grant_d && if_req;

    // Counts data grants that overtook a pending fetch; any fetch grant clears it.
    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (grant_d & if_req),
        .clr_i (grant_i),
        .sat_o (promote)
    );

    // Next state and command latches; a simultaneous rd/wr is issued as a write.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    we_d    = d_wr;
                    wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // A fetch only completes if the requester still wants the same address;
    // a redirected or flushed fetch finishes silently on the memory side.
    assign if_done = (state_q == I_BUSY) && mem_ack && if_req && (if_addr == addr_q);
    assign d_done  = (state_q == D_BUSY) && mem_ack && d_req;

    // Outputs are forced low while reset is held, even mid-transaction.
    assign if_ready  = !rst && if_done;
    assign d_ready   = !rst && d_done;
    assign if_rdata  = rst ? '0 : mem_rdata;
    assign d_rdata   = rst ? '0 : mem_rdata;
    assign mem_en    = !rst && (state_q != IDLE);
    assign mem_we    = !rst && we_q;
    assign mem_addr  = rst ? '0 : addr_q;
    assign mem_wdata = rst ? '0 : wdata_q;
    assign stall_if  = !rst && if_req && !if_done;
    assign stall_mem = !rst && d_req && !d_done;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch stage and its MEM stage. Arbitrates one outstanding transaction at a time with data-side priority and an instruction-starvation guard. Holds the memory-side command stable until acknowledge and generates per-stage stall signals consumed alongside the hazard unit's pcWrite/IF_ID write enables.

## Interface
- STARVE_MAX, 4: consecutive data grants that may bypass a waiting fetch before fetch is promoted; 0 disables promotion (strict data priority)
- AW, 32: address width
- DW, 32: data width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  fetched instruction, valid when if_ready
- if_ready  out  1  fetch completion, one-cycle pulse
- d_rd  in  1  MEM-stage load request (MemRead)
- d_wr  in  1  MEM-stage store request (MemWrite)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid when d_ready
- d_ready  out  1  data completion, one-cycle pulse
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one-cycle pulse
- stall_if  out  1  hold PC and IF/ID register
- stall_mem  out  1  hold EX/MEM and earlier stages

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE: d_req = d_rd|d_wr. Grant D if d_req and not (if_req and promote); else grant I if if_req; else stay. promote = (STARVE_MAX != 0) and starve_cnt == STARVE_MAX.
- On grant: latch addr (and we = d_wr, wdata for D) into command registers; transition to the BUSY state.
- d_rd and d_wr both high: treated as a write.
- BUSY: mem_en=1, mem_we/mem_addr/mem_wdata driven from latches, constant until mem_ack. On mem_ack return to IDLE.
- Completion (combinational): if_ready = I_BUSY & mem_ack & if_req & (if_addr == latched addr); d_ready = D_BUSY & mem_ack & d_req. rdata outputs = mem_rdata pass-through.
- Flushed/redirected fetch (if_req dropped or if_addr changed during I_BUSY): transaction completes, no if_ready, re-arbitrates from IDLE.
- starve_cnt: on D grant with if_req high, increment, saturating at STARVE_MAX; on I grant, clear to 0.
- stall_if = if_req & ~if_ready; stall_mem = d_req & ~d_ready.
- mem_ack in IDLE is ignored.

## Timing
- Reset: state IDLE, starve_cnt 0, all command latches 0; while rst high every output is 0, stalls included.
- rst mid-transaction: transaction abandoned; a later stray mem_ack arrives in IDLE and is ignored.
- Grant decision in IDLE cycle N; mem_en high from N+1; mem_ack permitted in N+1 or later (zero-wait memory supported).
- Minimum latency: request at N, ready at N+1. Peak throughput: one access per 2 cycles, with a mandatory IDLE cycle between transactions.
- Requester advances on the ready edge; its request in the next cycle is treated as new.

## Structure
- Shared package mem_arb_pkg: state encoding (IDLE=0, I_BUSY=1, D_BUSY=2), default STARVE_MAX.
- Sub-module starve_counter: saturating counter with inc/clr/sat outputs.
- Target 150–250 lines of RTL.

## Test plan
- Lone fetch if_addr=0x40, zero-wait ack -> mem_en at N+1 with addr 0x40, if_ready with rdata at N+1, stall_if high only at N.
- Simultaneous if_req and d_rd, addr 0x100 -> D served first; fetch granted in the IDLE after D ack; starve_cnt goes 0→1→0.
- Back-to-back loads for 6 transactions with if_req held, STARVE_MAX=4 -> grants D,D,D,D,I,D. With STARVE_MAX=0 -> all D first.
- Fetch redirect during I_BUSY (0x40→0x80) with a 3-cycle ack -> no if_ready; new fetch issued for 0x80.
- Store d_wr with 0xDEADBEEF to 0x20, ack delayed 2 cycles -> mem_we/addr/wdata stable until ack; d_ready pulses once.
- rst asserted in D_BUSY, ack arrives 1 cycle after release -> all outputs 0 during reset, ack ignored, no d_ready.
